// File: rtl/pool1_window_reader_pkg.sv
// Shared constants and FSM state type for the layer-1 pooled window reader.
package pool1_window_reader_pkg;

  localparam int MAP_W     = 12;                    // pooled map width/height
  localparam int MAP_N     = 32;                    // pooled maps (channels)
  localparam int K         = 3;                     // window size
  localparam int ADDR_W    = 13;                    // buffer address width
  localparam int MAP_TOTAL = MAP_N * MAP_W * MAP_W; // 4608 pooled bits
  localparam int OUT_W     = MAP_W - K + 1;         // 10 window positions per axis
  localparam int WIN_W     = K * K;                 // bits per window
  localparam int CH_W      = $clog2(MAP_N);         // 5
  localparam int POS_W     = $clog2(OUT_W);         // 4

  typedef enum logic [1:0] {
    CAPTURE,
    FETCH,
    PRESENT,
    DONE
  } state_t;

endpackage

// File: rtl/pool1_window_reader_bitbuf.sv
// 1-bit wide simple dual-port buffer: one write port, one synchronous read
// port with a single cycle of read latency.
module pool1_bitbuf #(
  parameter int DEPTH  = 4608,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data
);

  // NOTE: the array has no reset; every location is rewritten during capture
  // before it is read, so clearing it would only cost a multi-cycle sweep.
  logic r_mem [DEPTH];
  logic r_rd_data;

  // Write port: the caller guarantees wr_addr < DEPTH when wr_en is high.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Read port: registered output, valid the cycle after rd_en.
  always_ff @(posedge clk) begin
    if (rd_en) r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/pool1_window_reader.sv
// Captures the 32x12x12 pooled bit stream into a local buffer, then replays
// it as 3x3 windows (stride 1, channel fastest, then column, then row) over a
// valid/ready handshake for the layer-2 convolution.
module pool1_window_reader
  import pool1_window_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [WIN_W-1:0]  win_data,
  output logic [CH_W-1:0]   win_ch,
  output logic [POS_W-1:0]  win_row,
  output logic [POS_W-1:0]  win_col,
  output logic              win_last,
  output logic              done,
  output logic              overrun
);

  localparam int CNT_W  = $clog2(MAP_TOTAL + 1);
  localparam int FCNT_W = $clog2(WIN_W + 1);
  localparam int KK_W   = $clog2(K + 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cap_cnt;
  logic [FCNT_W-1:0]   r_fetch_cnt;
  logic [KK_W-1:0]     r_kr;
  logic [KK_W-1:0]     r_kc;
  logic [CH_W-1:0]     r_ch;
  logic [POS_W-1:0]    r_row;
  logic [POS_W-1:0]    r_col;
  logic [WIN_W-1:0]    r_win_data;
  logic                r_overrun;

  logic                w_wr_en;
  logic                w_rd_en;
  logic                w_rd_data;
  logic                w_accept;
  logic                w_last_pos;
  logic                w_cap_full;
  logic [ADDR_W-1:0]   w_rd_addr;

  // Only in-range addresses seen while capturing reach the buffer.
  assign w_wr_en    = in_valid && (r_state == CAPTURE) && (in_addr < ADDR_W'(MAP_TOTAL));
  assign w_cap_full = (r_cap_cnt == CNT_W'(MAP_TOTAL - 1));
  // Nine reads are issued on fetch counts 0..8; count 9 only absorbs the last return.
  assign w_rd_en    = (r_state == FETCH) && (r_fetch_cnt < FCNT_W'(WIN_W));
  assign w_accept   = (r_state == PRESENT) && win_ready;
  assign w_last_pos = (r_ch  == CH_W'(MAP_N - 1)) &&
                      (r_row == POS_W'(OUT_W - 1)) &&
                      (r_col == POS_W'(OUT_W - 1));

  // ch*144 + (row+kr)*12 + (col+kc), all at full address width.
  assign w_rd_addr = ADDR_W'(r_ch) * ADDR_W'(MAP_W * MAP_W)
                   + (ADDR_W'(r_row) + ADDR_W'(r_kr)) * ADDR_W'(MAP_W)
                   + ADDR_W'(r_col) + ADDR_W'(r_kc);

  pool1_bitbuf #(
    .DEPTH  (MAP_TOTAL),
    .ADDR_W (ADDR_W)
  ) u_bitbuf (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (in_addr),
    .wr_data (in_data),
    .rd_en   (w_rd_en),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

  // State register.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= CAPTURE;
    else     r_state <= w_next_state;
  end

  // Next-state decode.
  // NOTE: the default assignment first means no path leaves w_next_state
  // unassigned, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      CAPTURE: if (w_wr_en && w_cap_full)            w_next_state = FETCH;
      FETCH:   if (r_fetch_cnt == FCNT_W'(WIN_W))    w_next_state = PRESENT;
      PRESENT: if (win_ready)                        w_next_state = w_last_pos ? DONE : FETCH;
      DONE:                                          w_next_state = DONE;
      default:                                       w_next_state = CAPTURE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    win_valid = 1'b0;
    win_last  = 1'b0;
    done      = 1'b0;
    case (r_state)
      PRESENT: begin
        win_valid = 1'b1;
        win_last  = w_last_pos;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Capture counter and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_cnt <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr_en)                        r_cap_cnt <= r_cap_cnt + 1'b1;
      if (in_valid && r_state != CAPTURE) r_overrun <= 1'b1;
    end
  end

  // Fetch sequencer: kr-major read offsets and the window shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_kr        <= '0;
      r_kc        <= '0;
      r_win_data  <= '0;
    end else if (r_state == FETCH) begin
      r_fetch_cnt <= r_fetch_cnt + 1'b1;
      if (w_rd_en) begin
        if (r_kc == KK_W'(K - 1)) begin
          r_kc <= '0;
          r_kr <= r_kr + 1'b1;
        end else begin
          r_kc <= r_kc + 1'b1;
        end
      end
      // Read data trails its address by one cycle; shifting right lands
      // read 0 in bit 0 after the ninth shift.
      if (r_fetch_cnt != '0) r_win_data <= {w_rd_data, r_win_data[WIN_W-1:1]};
    end else begin
      r_fetch_cnt <= '0;
      r_kr        <= '0;
      r_kc        <= '0;
    end
  end

  // Window position: channel fastest, then column, then row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch  <= '0;
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept && !w_last_pos) begin
      if (r_ch == CH_W'(MAP_N - 1)) begin
        r_ch <= '0;
        if (r_col == POS_W'(OUT_W - 1)) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else begin
        r_ch <= r_ch + 1'b1;
      end
    end
  end

  assign win_data = r_win_data;
  assign win_ch   = r_ch;
  assign win_row  = r_row;
  assign win_col  = r_col;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_pool1_window_reader.sv
// Directed bench for pool1_window_reader: capture timing, out-of-range and
// duplicate writes, overrun, mid-stream reset, and a full 3200-window replay
// with consumer stalls against a bench-side copy of the captured maps.
module tb_pool1_window_reader;
  import pool1_window_reader_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [ADDR_W-1:0] in_addr;
  logic              in_data;
  logic              win_valid;
  logic              win_ready;
  logic [WIN_W-1:0]  win_data;
  logic [CH_W-1:0]   win_ch;
  logic [POS_W-1:0]  win_row;
  logic [POS_W-1:0]  win_col;
  logic              win_last;
  logic              done;
  logic              overrun;

  int checks = 0;
  int errors = 0;
  bit model_mem   [MAP_TOTAL];
  bit model_known [MAP_TOTAL];

  localparam int N_WIN = MAP_N * OUT_W * OUT_W;

  pool1_window_reader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_ch    (win_ch),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_last  (win_last),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One write strobe; the bench model follows the documented capture rules.
  task automatic write(input int addr, input bit d);
    in_valid = 1'b1;
    in_addr  = ADDR_W'(addr);
    in_data  = d;
    if (addr < MAP_TOTAL) begin
      model_mem[addr]   = d;
      model_known[addr] = 1'b1;
    end
    tick();
    in_valid = 1'b0;
  endtask

  function automatic void exp_window(input int ch, input int row, input int col,
                                     output logic [WIN_W-1:0] d, output logic [WIN_W-1:0] m);
    int a;
    for (int kr = 0; kr < K; kr++) begin
      for (int kc = 0; kc < K; kc++) begin
        a = ch * MAP_W * MAP_W + (row + kr) * MAP_W + (col + kc);
        d[kr*K+kc] = model_mem[a];
        m[kr*K+kc] = model_known[a];
      end
    end
  endfunction

  // Bounded wait for win_valid; optionally toggles win_ready while waiting.
  task automatic wait_valid(input bit rand_ready, output bit ok);
    int n = 0;
    while (win_valid !== 1'b1 && n < 40) begin
      if (rand_ready) win_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    win_ready = 1'b0;
    ok = (win_valid === 1'b1);
    check("wait_valid", win_valid, 1'b1);
  endtask

  // Check window idx, optionally stall, then optionally accept it.
  task automatic present(input int idx, input bit stalls, input bit accept, output bit ok);
    logic [WIN_W-1:0] d;
    logic [WIN_W-1:0] m;
    logic [13:0]      pos;
    int ch, row, col;
    ch  = idx % MAP_N;
    col = (idx / MAP_N) % OUT_W;
    row = idx / (MAP_N * OUT_W);
    wait_valid(stalls, ok);
    if (!ok) return;
    exp_window(ch, row, col, d, m);
    pos = {1'(idx == N_WIN - 1), CH_W'(ch), POS_W'(row), POS_W'(col)};
    check($sformatf("win%0d_data", idx), win_data & m, d & m);
    check($sformatf("win%0d_pos", idx), {win_last, win_ch, win_row, win_col}, pos);
    if (!accept) return;
    if (stalls) begin
      while ($urandom_range(0, 1) == 0) begin
        tick();
        check($sformatf("win%0d_hold", idx),
              {win_valid, win_last, win_ch, win_row, win_col, win_data & m}, {1'b1, pos, d & m});
      end
    end
    win_ready = 1'b1;
    tick();
    win_ready = 1'b0;
    check($sformatf("win%0d_drop", idx), win_valid, 1'b0);
  endtask

  initial begin
    bit ok;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = 1'b0;
    win_ready = 1'b0;
    tick();
    tick();
    check("rst_valid",   win_valid, 1'b0);
    check("rst_data",    win_data, 9'd0);
    check("rst_pos",     {win_last, win_ch, win_row, win_col}, 14'd0);
    check("rst_done",    done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    tick();

    // Run 1: parity data, address 0 written twice (1 then 0), two
    // out-of-range strobes, address 4607 never written.
    write(0, 1'b1);
    for (int a = 0; a < MAP_TOTAL - 2; a++) begin
      write(a, bit'(a & 1));
      if (a == 100)  write(MAP_TOTAL, 1'b1);
      if (a == 2000) write(8191, 1'b1);
    end
    for (int i = 0; i < 12; i++) tick();
    check("no_early_fetch", win_valid, 1'b0);
    write(MAP_TOTAL - 2, 1'b0);           // 4608th in-range strobe
    for (int i = 0; i < 9; i++) tick();
    check("lat9_valid", win_valid, 1'b0);
    tick();
    check("lat10_valid", win_valid, 1'b1);
    check("win0_hand_data", win_data, 9'b010_010_010);
    check("win0_hand_pos", {win_last, win_ch, win_row, win_col}, 14'd0);

    // Strobe during PRESENT: ignored for the buffer, sets sticky overrun.
    in_valid = 1'b1;
    in_addr  = ADDR_W'(13);
    in_data  = 1'b0;
    tick();
    in_valid = 1'b0;
    check("ovr_set",   overrun, 1'b1);
    check("ovr_valid", win_valid, 1'b1);
    check("ovr_data",  win_data, 9'b010_010_010);
    for (int i = 0; i < 3; i++) tick();
    check("ovr_sticky", overrun, 1'b1);

    ok = 1'b1;
    for (int idx = 0; idx < 1000 && ok; idx++) present(idx, 1'b0, 1'b1, ok);
    if (ok) present(1000, 1'b0, 1'b0, ok);

    // Reset while window 1000 is presented, with competing ready and strobe.
    rst       = 1'b1;
    win_ready = 1'b1;
    in_valid  = 1'b1;
    in_addr   = ADDR_W'(5);
    tick();
    rst       = 1'b0;
    win_ready = 1'b0;
    in_valid  = 1'b0;
    check("mid_rst_valid",   win_valid, 1'b0);
    check("mid_rst_done",    done, 1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    check("mid_rst_pos",     {win_last, win_ch, win_row, win_col}, 14'd0);
    check("mid_rst_data",    win_data, 9'd0);

    // Run 2: checkerboard per channel, channel 5 all ones, random stalls.
    for (int a = 0; a < MAP_TOTAL; a++) begin
      int ch, r, c;
      ch = a / (MAP_W * MAP_W);
      r  = (a % (MAP_W * MAP_W)) / MAP_W;
      c  = a % MAP_W;
      write(a, (ch == 5) ? 1'b1 : bit'((r + c) & 1));
    end
    ok = 1'b1;
    for (int idx = 0; idx < N_WIN && ok; idx++) present(idx, 1'b1, 1'b1, ok);
    check("end_done",    done, 1'b1);
    check("end_valid",   win_valid, 1'b0);
    check("end_overrun", overrun, 1'b0);

    // Strobe in DONE sets overrun; done stays high and nothing is presented.
    in_valid  = 1'b1;
    in_addr   = '0;
    win_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    tick();
    win_ready = 1'b0;
    check("done_overrun", overrun, 1'b1);
    check("done_hold",    done, 1'b1);
    check("done_valid",   win_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool1_window_reader.md
Name: pool1_window_reader

Overview:
Consumes the layer-1 pooled-result stream of 32 binary 12x12 maps (4608 bits, 13-bit address) and stores it in an internal 1-bit buffer. Once all 4608 results are captured, it reads the buffer back as 3x3 binary windows, stride 1, for the layer-2 convolution. Windows are emitted one channel at a time over a valid/ready handshake. It sits between the layer-1 pooling stage (the writer) and the conv_2 datapath (the consumer).

Parameters:
MAP_W, 12, pooled map width/height
MAP_N, 32, number of pooled maps (channels)
K, 3, window size
ADDR_W, 13, address width; must satisfy 2^ADDR_W >= MAP_N*MAP_W*MAP_W
OUT_W, MAP_W-K+1 (10), window positions per row/column; derived, not overridable

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  single-cycle strobe: in_addr/in_data valid
in_addr  in  ADDR_W  pooled address = ch*144 + row*12 + col
in_data  in  1  pooled bit
win_valid  out  1  window valid
win_ready  in  1  consumer accepts window
win_data  out  K*K  window bits; bit kr*3+kc = map[row+kr][col+kc]
win_ch  out  5  channel of window
win_row  out  4  window top row, 0..9
win_col  out  4  window left column, 0..9
win_last  out  1  high with the final window (ch 31, row 9, col 9)
done  out  1  all windows accepted
overrun  out  1  sticky: in_valid seen outside CAPTURE

Behaviour:
- Reset values: win_valid=0, win_data=0, win_ch/row/col=0, win_last=0, done=0, overrun=0. State = CAPTURE; capture count = 0; row/col/ch = 0. Buffer contents are not cleared.
- Buffer: 4608x1, one write port and one read port. Read is synchronous with 1-cycle latency.
- CAPTURE:
  - On in_valid with in_addr < 4608: write in_data to the buffer and increment the capture count.
  - in_addr >= 4608: ignored, not counted.
  - Duplicate addresses are counted; the last write wins.
  - When the count reaches 4608, go to FETCH on the next cycle.
- FETCH:
  - Issue 9 reads on consecutive cycles, kr-major then kc.
  - Read address = ch*144 + (row+kr)*12 + (col+kc), computed at 13-bit width with no truncation.
  - Each returned bit is shifted into its win_data position one cycle after its read is issued.
  - win_valid rises 10 cycles after entry to FETCH, together with the transition to PRESENT.
- PRESENT:
  - win_valid, win_data, win_ch, win_row, win_col and win_last are held stable until win_valid & win_ready.
  - On acceptance, win_valid drops the next cycle.
  - Advance order: ch fastest (0..31), then col (0..9), then row (0..9).
  - If more windows remain, go to FETCH; otherwise go to DONE.
  - win_ready high while win_valid=0 has no effect. No back-to-back windows: minimum 10 cycles between acceptances.
- DONE: done=1, held until rst. win_valid=0.
- in_valid in FETCH, PRESENT or DONE: ignored (no buffer write) and sets overrun until rst.
- rst mid-operation takes priority over every event in the same cycle and returns the block to CAPTURE. An in-flight window is abandoned without being presented.
- Total windows = 32*10*10 = 3200.

Decomposition:
- Shared package: MAP_W, MAP_N, K, pooled-map total (4608), and the state enum {CAPTURE, FETCH, PRESENT, DONE}.
- One natural sub-module: pool1_bitbuf, a 4608x1 simple dual-port RAM with 1-cycle read latency.
- Address generation, the window shift register and the FSM stay in the top module.

Test Plan:
- Write all 4608 addresses with in_data=addr[0], win_ready=1 -> first window ch0/row0/col0 has win_data=9'b010_010_010... evaluated per address parity (addresses 0,1,2,12,13,14,24,25,26). win_valid rises exactly 10 cycles after the 4608th write enters FETCH.
- Capture a checkerboard per channel, with channel 5 all-ones, and random win_ready stalls (50%) -> all 3200 windows match the reference model in order (ch fastest). Outputs are held stable during stalls. win_last is asserted only on ch31/row9/col9. done=1 after that acceptance.
- Send addr 4608 and 8191 during capture, plus 4608 valid writes -> out-of-range writes are not counted; the transition occurs only after the 4608th in-range write.
- Pulse in_valid during PRESENT -> overrun=1 and sticky; window data unchanged; buffer unchanged (verified by later windows).
- Assert rst while win_valid=1 mid-stream (window 1000), then recapture -> win_valid=0, done=0, overrun=0 the cycle after rst. The stream restarts at ch0/row0/col0.
- Write address 0 twice (1 then 0) among the 4608 writes, i.e. 4607 unique addresses -> FETCH starts after the 4608th strobe. Window ch0/row0/col0 bit 0 = 0. Address 4607 was never written, so its window bit is don't-care and the check is masked.
